// File: rtl/prim_ram_bist_pkg.sv
// Shared types and the March C- element table for the single-port RAM BIST.
// Behaviour on mismatch is selected by PRIM_RAM_BIST_CONT_EN (see prim_ram_bist_chk).
package prim_ram_bist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // rw: 1 = write, 0 = read; data is the written or expected background bit
  typedef struct packed {
    logic rw;
    logic data;
  } march_op_t;

  typedef struct packed {
    logic            dir;   // 0 = ascending, 1 = descending
    logic [1:0]      nops;
    march_op_t [0:1] ops;
  } march_elem_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  localparam march_op_t W0 = '{rw: 1'b1, data: 1'b0};
  localparam march_op_t W1 = '{rw: 1'b1, data: 1'b1};
  localparam march_op_t R0 = '{rw: 1'b0, data: 1'b0};
  localparam march_op_t R1 = '{rw: 1'b0, data: 1'b1};

  localparam int NUM_ELEMS = 6;

  localparam march_elem_t MARCH_C_MINUS [NUM_ELEMS] = '{
    '{dir: DIR_UP, nops: 2'd1, ops: {W0, W0}},
    '{dir: DIR_UP, nops: 2'd2, ops: {R0, W1}},
    '{dir: DIR_UP, nops: 2'd2, ops: {R1, W0}},
    '{dir: DIR_DN, nops: 2'd2, ops: {R0, W1}},
    '{dir: DIR_DN, nops: 2'd2, ops: {R1, W0}},
    '{dir: DIR_UP, nops: 2'd1, ops: {R0, R0}}
  };

endpackage

// File: rtl/prim_ram_1p_bist_if.sv
// prim_ram_1p style RAM port: the BIST is the master, the RAM instance the slave.
interface prim_ram_1p_bist_if #(
  parameter int Width = 32,
  parameter int Depth = 128
);
  localparam int Aw = $clog2(Depth);

  logic             req;
  logic             write;
  logic [Aw-1:0]    addr;
  logic [Width-1:0] wdata;
  logic [Width-1:0] wmask;
  logic [Width-1:0] rdata;

  modport master (output req, write, addr, wdata, wmask, input rdata);
  modport slave  (input req, write, addr, wdata, wmask, output rdata);
endinterface

// File: rtl/prim_ram_bist_chk.sv
// Read compare stage plus error capture. PRIM_RAM_BIST_CONT_EN defined: keep going
// after mismatches and accumulate; undefined: request an abort on the first one.
module prim_ram_bist_chk #(
  parameter int Width = 32,
  parameter int Aw    = 7
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             rd_i,
  input  logic [Aw-1:0]    addr_i,
  input  logic             exp_i,
  input  logic             cmp_en_i,
  input  logic [Width-1:0] rdata_i,
  output logic             abort_o,
  output logic [Aw-1:0]    err_addr_o,
  output logic [Width-1:0] err_bits_o,
  output logic [15:0]      err_cnt_o
);

  logic             vld_q;
  logic             exp_q;
  logic [Aw-1:0]    addr_q;
  logic [Width-1:0] diff;
  logic             mis;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      vld_q  <= 1'b0;
      exp_q  <= 1'b0;
      addr_q <= '0;
    end else begin
      vld_q  <= rd_i;
      exp_q  <= exp_i;
      addr_q <= addr_i;
    end
  end

  assign diff = rdata_i ^ {Width{exp_q}};
  // cmp_en_i masks a read still in flight when the FSM has already left RUN/DRAIN
  assign mis  = vld_q & cmp_en_i & (|diff);

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      err_addr_o <= '0;
      err_bits_o <= '0;
      err_cnt_o  <= '0;
    end else if (mis) begin
      if (err_cnt_o == 16'd0) err_addr_o <= addr_q;
      err_bits_o <= err_bits_o | diff;
      if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
    end
  end

`ifdef PRIM_RAM_BIST_CONT_EN
  assign abort_o = 1'b0;
`else
  assign abort_o = mis;
`endif

endmodule

// File: rtl/prim_ram_1p_bist.sv
// March C- BIST initiator for one prim_ram_1p RAM; one op per cycle while busy.
// Mismatch handling follows PRIM_RAM_BIST_CONT_EN (abort when undefined).
module prim_ram_1p_bist
  import prim_ram_bist_pkg::*;
#(
  parameter int  Width = 32,
  parameter int  Depth = 128,
  localparam int Aw    = $clog2(Depth)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [Aw-1:0]       err_addr_o,
  output logic [Width-1:0]    err_bits_o,
  output logic [15:0]         err_cnt_o,
  prim_ram_1p_bist_if.master  mem
);

  state_e        state;
  logic [2:0]    elem;
  logic          op_idx;
  logic [Aw-1:0] addr;
  march_elem_t   cur;
  march_op_t     op;
  logic [2:0]    nxt_elem;
  logic          run, last_op, last_addr, last_elem, abort, clr;

  assign cur       = MARCH_C_MINUS[elem];
  assign op        = cur.ops[op_idx];
  assign nxt_elem  = elem + 3'd1;
  assign run       = (state == RUN);
  assign last_op   = (cur.nops == 2'd1) | op_idx;
  assign last_addr = cur.dir ? (addr == '0) : (addr == Aw'(Depth - 1));
  assign last_elem = (elem == 3'(NUM_ELEMS - 1));
  assign clr       = start_i & ((state == IDLE) | (state == DONE));

  assign mem.req   = run;
  assign mem.write = run & op.rw;
  assign mem.addr  = addr;
  assign mem.wdata = {Width{run & op.data}};
  assign mem.wmask = '1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      elem   <= '0;
      op_idx <= 1'b0;
      addr   <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start_i) begin
          state  <= RUN;
          elem   <= '0;
          op_idx <= 1'b0;
          addr   <= '0;
          busy_o <= 1'b1;
          done_o <= 1'b0;
        end
        RUN: begin
          // the op on the bus during an abort still completes this cycle
          if (abort) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else if (!last_op) begin
            op_idx <= 1'b1;
          end else begin
            op_idx <= 1'b0;
            if (!last_addr) addr <= cur.dir ? addr - Aw'(1) : addr + Aw'(1);
            else if (last_elem) state <= DRAIN;
            else begin
              elem <= nxt_elem;
              addr <= MARCH_C_MINUS[nxt_elem].dir ? Aw'(Depth - 1) : '0;
            end
          end
        end
        DRAIN: begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  prim_ram_bist_chk #(.Width(Width), .Aw(Aw)) u_chk (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr),
    .rd_i       (run & ~op.rw),
    .addr_i     (addr),
    .exp_i      (op.data),
    .cmp_en_i   (run | (state == DRAIN)),
    .rdata_i    (mem.rdata),
    .abort_o    (abort),
    .err_addr_o (err_addr_o),
    .err_bits_o (err_bits_o),
    .err_cnt_o  (err_cnt_o)
  );

  assign pass_o = done_o & (err_cnt_o == 16'd0);

endmodule

// File: tb/tb_prim_ram_1p_bist.sv
// Scoreboard bench: a march-table model predicts every RAM op and the final
// verdict; monitors compare whatever the DUTs present against the queues.
module tb_prim_ram_1p_bist;

`ifdef PRIM_RAM_BIST_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct { bit wr; int addr; bit data; } op_t;
  typedef struct { int done; bit pass; int ea; logic [31:0] eb; int cnt; } res_t;

  localparam int EL_N  [6]    = '{1, 2, 2, 2, 2, 1};
  localparam bit EL_DN [6]    = '{0, 0, 0, 1, 1, 0};
  localparam bit EL_WR [6][2] = '{'{1, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  localparam bit EL_D  [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  prim_ram_1p_bist_if #(.Width(32), .Depth(128)) mem_a ();
  prim_ram_1p_bist_if #(.Width(32), .Depth(100)) mem_b ();

  logic busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [6:0] ea_a, ea_b;
  logic [31:0] eb_a, eb_b;
  logic [15:0] ec_a, ec_b;

  prim_ram_1p_bist #(.Width(32), .Depth(128)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
    .pass_o(pass_a), .err_addr_o(ea_a), .err_bits_o(eb_a), .err_cnt_o(ec_a), .mem(mem_a));
  prim_ram_1p_bist #(.Width(32), .Depth(100)) dut100 (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
    .pass_o(pass_b), .err_addr_o(ea_b), .err_bits_o(eb_b), .err_cnt_o(ec_b), .mem(mem_b));

  // RAM models; instance A carries a single stuck-at bit
  logic [31:0] ram_a [128];
  logic [31:0] ram_b [100];
  bit f_en = 0, f_val = 0;
  int f_addr = 0, f_bit = 0;

  function automatic logic [31:0] faulty(logic [31:0] d, int a);
    if (f_en && a == f_addr) d[f_bit] = f_val;
    return d;
  endfunction

  always @(posedge clk) if (mem_a.req) begin
    if (mem_a.write) ram_a[mem_a.addr] <= mem_a.wdata & mem_a.wmask;
    else mem_a.rdata <= faulty(ram_a[mem_a.addr], int'(mem_a.addr));
  end
  always @(posedge clk) if (mem_b.req) begin
    if (mem_b.write) begin
      if (mem_b.addr < 7'd100) ram_b[mem_b.addr] <= mem_b.wdata & mem_b.wmask;
    end else mem_b.rdata <= (mem_b.addr < 7'd100) ? ram_b[mem_b.addr] : 32'hx;
  end

  int n_chk = 0, n_err = 0;
  int t0a = 0, t0b = 0;
  bit b_oor = 0;
  op_t march_q[$], op_qa[$], op_qb[$];
  res_t res_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  task automatic build_march(input int depth);
    march_q.delete();
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < depth; k++)
        for (int o = 0; o < EL_N[e]; o++)
          march_q.push_back('{wr: EL_WR[e][o], addr: EL_DN[e] ? depth - 1 - k : k, data: EL_D[e][o]});
  endtask

  // walk the march against an ideal RAM plus the injected fault
  task automatic predict(input int limit, input bit push_res);
    logic [31:0] m [128];
    logic [31:0] rd, bg, eb;
    int n, last, done, cnt, ea;
    op_t o;
    build_march(128);
    n = march_q.size(); last = n - 1; done = n + 2; cnt = 0; ea = 0; eb = '0;
    for (int i = 0; i < n; i++) begin
      o = march_q[i];
      bg = {32{o.data}};
      if (o.wr) m[o.addr] = bg;
      else begin
        rd = m[o.addr];
        if (f_en && o.addr == f_addr) rd[f_bit] = f_val;
        if (rd != bg) begin
          if (cnt == 0) ea = o.addr;
          eb |= rd ^ bg;
          if (cnt < 65535) cnt++;
          if (!CONT) begin
            last = (i + 1 < n) ? i + 1 : n - 1;
            done = i + 3;
            break;
          end
        end
      end
    end
    if (last > limit - 1) last = limit - 1;
    for (int i = 0; i <= last; i++) op_qa.push_back(march_q[i]);
    if (push_res) res_q.push_back('{done: done, pass: (cnt == 0), ea: ea, eb: eb, cnt: cnt});
  endtask

  initial begin : mon_a
    res_t r;
    bit dprev = 0;
    forever begin
      @(negedge clk);
      if (mem_a.req === 1'b1) begin
        if (op_qa.size() == 0) chk("a_extra_op", {mem_a.write, mem_a.addr}, 0);
        else begin
          chk("a_op", {mem_a.write, mem_a.addr, mem_a.write ? mem_a.wdata : 32'h0},
              {op_qa[0].wr, 7'(op_qa[0].addr), op_qa[0].wr ? {32{op_qa[0].data}} : 32'h0});
          op_qa.delete(0);
        end
      end
      if (done_a === 1'b1 && !dprev) begin
        if (res_q.size() == 0) chk("a_unexpected_done", 1, 0);
        else begin
          r = res_q.pop_front();
          chk("a_done_cycle", cyc - t0a, r.done);
          chk("a_pass", pass_a, r.pass);
          chk("a_err_addr", ea_a, r.ea);
          chk("a_err_bits", eb_a, r.eb);
          chk("a_err_cnt", ec_a, r.cnt);
          chk("a_busy_at_done", busy_a, 0);
        end
      end
      dprev = (done_a === 1'b1);
    end
  end

  initial begin : mon_b
    forever begin
      @(negedge clk);
      if (mem_b.req === 1'b1) begin
        if (mem_b.addr > 7'd99) b_oor = 1;
        if (op_qb.size() == 0) chk("b_extra_op", {mem_b.write, mem_b.addr}, 0);
        else begin
          chk("b_op", {mem_b.write, mem_b.addr, mem_b.write ? mem_b.wdata : 32'h0},
              {op_qb[0].wr, 7'(op_qb[0].addr), op_qb[0].wr ? {32{op_qb[0].data}} : 32'h0});
          op_qb.delete(0);
        end
      end
    end
  end

  task automatic run_a(input bit fe, input int fa, input int fb, input bit fv, input int hold);
    int k;
    f_en = fe; f_addr = fa; f_bit = fb; f_val = fv;
    predict(1 << 30, 1'b1);
    @(negedge clk); start_a = 1'b1; t0a = cyc;
    @(negedge clk);
    chk("a_busy_c1", busy_a, 1);
    chk("a_cleared_c1", {done_a, pass_a, ec_a, ea_a, eb_a}, 0);
    if (hold <= 1) start_a = 1'b0;
    k = 1;
    while (done_a !== 1'b1 && k < 3000) begin
      if (k == hold) start_a = 1'b0;
      @(negedge clk); k++;
    end
    start_a = 1'b0;
    if (k >= 3000) chk("a_done_timeout", k, 0);
    repeat (2) @(negedge clk);
    chk("a_ops_left", op_qa.size(), 0);
    chk("a_res_left", res_q.size(), 0);
    op_qa.delete(); res_q.delete();
  endtask

  task automatic run_rst();
    f_en = 0;
    predict(500, 1'b0);
    @(negedge clk); start_a = 1'b1; t0a = cyc;
    @(negedge clk); start_a = 1'b0;
    while (cyc - t0a < 500) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_ctl", {mem_a.req, mem_a.write, busy_a, done_a, pass_a}, 0);
    chk("rst_mid_bus", {mem_a.addr, mem_a.wdata, ea_a}, 0);
    chk("rst_mid_err", {eb_a, ec_a}, 0);
    repeat (2) @(negedge clk);
    chk("rst_ops_left", op_qa.size(), 0);
    op_qa.delete();
  endtask

  task automatic run_b();
    int k;
    build_march(100);
    op_qb = march_q;
    b_oor = 0;
    @(negedge clk); start_b = 1'b1; t0b = cyc;
    @(negedge clk); start_b = 1'b0;
    k = 1;
    while (done_b !== 1'b1 && k < 3000) begin
      @(negedge clk); k++;
      if (cyc - t0b == 501) chk("b_first_down_op", {mem_b.write, mem_b.addr}, {1'b0, 7'd99});
    end
    if (k >= 3000) chk("b_done_timeout", k, 0);
    chk("b_done_cycle", cyc - t0b, 1002);
    chk("b_pass", pass_b, 1);
    chk("b_err_cnt", ec_b, 0);
    chk("b_addr_range", b_oor, 0);
    repeat (2) @(negedge clk);
    chk("b_ops_left", op_qb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctl_a", {busy_a, done_a, pass_a, mem_a.req, mem_a.write}, 0);
    chk("reset_bus_a", {mem_a.addr, mem_a.wdata, ea_a}, 0);
    chk("reset_err_a", {eb_a, ec_a}, 0);
    chk("reset_ctl_b", {busy_b, done_b, pass_b, mem_b.req, ec_b}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_req", {mem_a.req, busy_a, done_a}, 0);

    run_a(0, 0, 0, 0, 0);         // clean RAM
    run_a(1, 16, 5, 1, 0);        // stuck-at-1, bit 5 @ 0x10
    run_a(0, 0, 0, 0, 0);         // restart from DONE after a failure
    run_a(0, 0, 0, 0, 300);       // start held high during RUN
    run_rst();
    run_a(0, 0, 0, 0, 0);         // fresh run after mid-test reset
    run_a(1, 127, 31, 0, 0);      // stuck-at-0 at the top address
    for (int i = 0; i < 4; i++)
      run_a(1, $urandom_range(0, 127), $urandom_range(0, 31), 1'($urandom_range(0, 1)), 0);
    run_b();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
